// File: rtl/mvm_gen.sv
// Matrix-vector multiplier: loads a KxK signed matrix and K-vector, then emits y = M*v.
// Latency: done is sampled K*K/P+1 edges after the edge that samples start; K results follow back to back.
// Backpressure: none on the output burst; loads stall on in_valid=0 with no timeout.
//
// Ports:
//   clk, reset (async, active low)
//   loadMatrix / loadVector / start : one-cycle command pulses, honoured only in IDLE
//   in_valid, data_in               : load data (matrix row-major, vector index 0 first)
//   busy, done, out_valid, data_out : status and result stream (data_out holds between bursts)
module mvm_gen #(
  parameter int K     = 4,
  parameter int P     = 1,
  parameter int B     = 8,
  parameter int OUT_W = 2*B + $clog2(K)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    loadMatrix,
  input  logic                    loadVector,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic signed [B-1:0]     data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] data_out
);

  localparam int FW = 2*B + $clog2(K);          // full-precision accumulator width
  localparam int EW = (FW > OUT_W) ? FW : OUT_W; // common width for the saturation compare
  localparam int CH = K / P;                     // column chunks per row
  localparam int MW = $clog2(K*K);
  localparam int VW = $clog2(K);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_M, S_LOAD_V, S_COMPUTE, S_DONE, S_OUTPUT
  } state_t;

  state_t                  state_q, state_d;
  logic [MW-1:0]           idx_q;
  logic [VW-1:0]           row_q, out_q;
  logic [CW-1:0]           chunk_q;
  logic                    mat_loaded_q, vec_loaded_q;
  logic signed [FW-1:0]    acc_q, acc_sum;
  logic signed [OUT_W-1:0] data_out_q;
  logic                    last_chunk, last_row;

  logic signed [B-1:0]     m_q [K*K];
  logic signed [B-1:0]     v_q [K];
  logic signed [OUT_W-1:0] y_q [K];

  // Clamp a full-precision sum into OUT_W; degenerates to sign extension when OUT_W >= FW.
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [FW-1:0] a);
    logic signed [EW-1:0] ext, maxv, minv;
    ext  = EW'(a);
    maxv = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    minv = ~maxv;
    if (ext > maxv)      return maxv[OUT_W-1:0];
    else if (ext < minv) return minv[OUT_W-1:0];
    else                 return ext[OUT_W-1:0];
  endfunction

  assign last_chunk = (chunk_q == CW'(CH-1));
  assign last_row   = (row_q == VW'(K-1));

  // P products of the current row chunk added onto the running row sum.
  always_comb begin
    logic signed [2*B-1:0] prod;
    logic signed [FW-1:0]  prod_ext;
    int                    col;
    acc_sum  = acc_q;
    prod     = '0;
    prod_ext = '0;
    col      = 0;
    for (int p = 0; p < P; p++) begin
      col      = int'(chunk_q) * P + p;
      prod     = m_q[MW'(int'(row_q) * K + col)] * v_q[VW'(col)];
      prod_ext = {{(FW-2*B){prod[2*B-1]}}, prod};
      acc_sum  = acc_sum + prod_ext;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (loadMatrix)                                     state_d = S_LOAD_M;
        else if (loadVector)                                state_d = S_LOAD_V;
        else if (start && mat_loaded_q && vec_loaded_q)     state_d = S_COMPUTE;
      end
      S_LOAD_M:  if (in_valid && idx_q == MW'(K*K-1)) state_d = S_IDLE;
      S_LOAD_V:  if (in_valid && idx_q == MW'(K-1))   state_d = S_IDLE;
      S_COMPUTE: if (last_row && last_chunk)          state_d = S_DONE;
      S_DONE:                                         state_d = S_OUTPUT;
      S_OUTPUT:  if (out_q == VW'(K-1))               state_d = S_IDLE;
      default:                                        state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    out_valid = (state_q == S_OUTPUT);
    data_out  = data_out_q;
  end

  // Control counters, operand flags and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      row_q        <= '0;
      chunk_q      <= '0;
      out_q        <= '0;
      mat_loaded_q <= 1'b0;
      vec_loaded_q <= 1'b0;
      acc_q        <= '0;
      data_out_q   <= '0;
    end else begin
      unique case (state_q)
        S_LOAD_M: if (in_valid) begin
          if (idx_q == MW'(K*K-1)) begin
            idx_q        <= '0;
            mat_loaded_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_LOAD_V: if (in_valid) begin
          if (idx_q == MW'(K-1)) begin
            idx_q        <= '0;
            vec_loaded_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (last_chunk) begin
            // Row finished: its sum goes to y_q, accumulator restarts for the next row.
            acc_q   <= '0;
            chunk_q <= '0;
            row_q   <= last_row ? '0 : row_q + 1'b1;
          end else begin
            acc_q   <= acc_sum;
            chunk_q <= chunk_q + 1'b1;
          end
        end
        S_DONE: data_out_q <= y_q[0];
        S_OUTPUT: begin
          if (out_q == VW'(K-1)) begin
            out_q <= '0;
          end else begin
            out_q      <= out_q + 1'b1;
            data_out_q <= y_q[out_q + 1'b1];
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and result storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_M && in_valid) m_q[idx_q] <= data_in;
    if (state_q == S_LOAD_V && in_valid) v_q[idx_q[VW-1:0]] <= data_in;
    if (state_q == S_COMPUTE && last_chunk) y_q[row_q] <= sat(acc_sum);
  end

endmodule
